// File: rtl/axi_mem_pkg.sv
// Shared types for the axi_memory slave: response codes, burst kinds and FSM states.
package axi_mem_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    BURST_FIXED = 1'b0,
    BURST_INCR  = 1'b1
  } burst_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

endpackage

// File: rtl/axi_mem_array.sv
// Word storage for axi_memory: cleared on reset, one write port, one registered read port.
module axi_mem_array
  import axi_mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int memory_size = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [memory_size];

  // Read samples the pre-edge contents, so a same-edge write is seen only by later reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < memory_size; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/axi_memory.sv
// Word-addressed AXI-style memory slave with burst writes and single-beat reads.
// Define AXI_MEM_BOUNDS_CHECK_EN to reject out-of-range addresses instead of wrapping them.
module axi_memory
  import axi_mem_pkg::*;
#(
  parameter int word_size   = 32,
  parameter int memory_size = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  AWBURST,
  input  logic [7:0]            AWLEN,
  input  logic                  WVALID,
  output logic                  WREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  WLAST,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic [1:0]            BRESP,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  input  logic                  W_EN,
  input  logic                  R_EN
);

  localparam int AW1 = ADDR_WIDTH + 1;

  // One spare address bit lets the burst pointer reach memory_size without overflowing.
  function automatic logic [ADDR_WIDTH-1:0] wrap_addr(input logic [ADDR_WIDTH:0] a);
    return ADDR_WIDTH'(a % AW1'(memory_size));
  endfunction

`ifdef AXI_MEM_BOUNDS_CHECK_EN
  function automatic logic in_range(input logic [ADDR_WIDTH:0] a);
    return a < AW1'(memory_size);
  endfunction
`endif

  w_state_t            w_state, w_state_nxt;
  r_state_t            r_state, r_state_nxt;
  logic [ADDR_WIDTH:0] w_addr, w_addr_nxt;
  logic [7:0]          w_cnt, w_len;
  burst_t              w_burst;
  logic                w_err;
  logic                r_ok;
  resp_t               r_resp;
  logic                aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                w_final, beat_ok, rd_ok, mem_we;
  logic [DATA_WIDTH-1:0] arr_rdata;

  assign aw_hs   = AWVALID && (w_state == W_IDLE);
  assign w_hs    = WVALID  && (w_state == W_DATA);
  assign b_hs    = BREADY  && (w_state == W_RESP);
  assign ar_hs   = ARVALID && (r_state == R_IDLE);
  assign r_hs    = RREADY  && (r_state == R_DATA);
  assign w_final = WLAST || (w_cnt == w_len - 8'd1);

`ifdef AXI_MEM_BOUNDS_CHECK_EN
  assign beat_ok    = in_range(w_addr);
  assign rd_ok      = R_EN && in_range({1'b0, ARADDR});
  assign w_addr_nxt = (w_burst == BURST_INCR && in_range(w_addr)) ? w_addr + AW1'(1) : w_addr;
`else
  assign beat_ok    = 1'b1;
  assign rd_ok      = R_EN;
  assign w_addr_nxt = (w_burst == BURST_INCR) ? {1'b0, wrap_addr(w_addr)} + AW1'(1) : w_addr;
`endif

  assign mem_we = w_hs && W_EN && beat_ok;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    r_state_nxt = r_state;
    AWREADY     = 1'b0;
    WREADY      = 1'b0;
    BVALID      = 1'b0;
    BRESP       = RESP_OKAY;
    ARREADY     = 1'b0;
    RVALID      = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        AWREADY = ARESETn;
        if (aw_hs) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        WREADY = 1'b1;
        if (w_hs && w_final) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        BVALID = 1'b1;
        BRESP  = w_err ? RESP_SLVERR : RESP_OKAY;
        if (b_hs) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
    unique case (r_state)
      R_IDLE: begin
        ARREADY = ARESETn;
        if (ar_hs) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        RVALID = 1'b1;
        if (r_hs) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_addr  <= '0;
      w_cnt   <= '0;
      w_len   <= 8'd1;
      w_burst <= BURST_FIXED;
      w_err   <= 1'b0;
    end else if (aw_hs) begin
      w_addr  <= {1'b0, AWADDR};
      w_cnt   <= '0;
      w_len   <= (AWLEN == 8'd0) ? 8'd1 : AWLEN;
      w_burst <= burst_t'(AWBURST);
      w_err   <= 1'b0;
    end else if (w_hs) begin
      w_addr <= w_addr_nxt;
      w_cnt  <= w_cnt + 8'd1;
      if (!W_EN || !beat_ok) w_err <= 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_ok   <= 1'b0;
      r_resp <= RESP_OKAY;
    end else if (ar_hs) begin
      r_ok   <= rd_ok;
      r_resp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign RDATA = r_ok ? arr_rdata : '0;
  assign RRESP = r_resp;

  axi_mem_array #(
    .DATA_WIDTH (word_size),
    .ADDR_WIDTH (ADDR_WIDTH),
    .memory_size(memory_size)
  ) u_array (
    .clk    (ACLK),
    .rst_n  (ARESETn),
    .wr_en  (mem_we),
    .wr_addr(wrap_addr(w_addr)),
    .wr_data(WDATA),
    .rd_en  (ar_hs),
    .rd_addr(wrap_addr({1'b0, ARADDR})),
    .rd_data(arr_rdata)
  );

endmodule

// File: tb/tb_axi_memory.sv
// Scoreboard bench for axi_memory: directed bursts and reads, responses checked by a monitor.
module tb_axi_memory;
  import axi_mem_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic          AWVALID = 1'b0, AWREADY;
  logic [AW-1:0] AWADDR = '0;
  logic          AWBURST = 1'b0;
  logic [7:0]    AWLEN = '0;
  logic          WVALID = 1'b0, WREADY;
  logic [DW-1:0] WDATA = '0;
  logic          WLAST = 1'b0;
  logic          BVALID, BREADY = 1'b0;
  logic [1:0]    BRESP;
  logic          ARVALID = 1'b0, ARREADY;
  logic [AW-1:0] ARADDR = '0;
  logic          RVALID, RREADY = 1'b0;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic          W_EN = 1'b1, R_EN = 1'b1;

  always #5 ACLK = ~ACLK;

  axi_memory #(
    .word_size(32), .memory_size(32), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWBURST(AWBURST), .AWLEN(AWLEN),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .W_EN(W_EN), .R_EN(R_EN)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
  } rexp_t;

  int          checks = 0;
  int          errors = 0;
  logic [1:0]  bq[$];
  rexp_t       rq[$];
  logic [31:0] wbuf[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: return AWREADY;
      1: return WREADY;
      2: return ARREADY;
      3: return BVALID;
      default: return RVALID;
    endcase
  endfunction

  task automatic wait_for(input int which, input logic level, input string name);
    int t = 0;
    while (sig(which) !== level && t < 50) begin
      @(posedge ACLK); #1;
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: got %0b expected %0b", name, sig(which), level);
    end
  endtask

  // Response monitor: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge ACLK) begin
    if (ARESETn && BVALID && BREADY) begin
      if (bq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bresp_unexpected: got 0x%0h expected none", BRESP);
      end else begin
        check("bresp", 32'(BRESP), 32'(bq.pop_front()));
      end
    end
    if (ARESETn && RVALID && RREADY) begin
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rdata_unexpected: got 0x%0h expected none", RDATA);
      end else begin
        rexp_t e;
        e = rq.pop_front();
        check("rdata", RDATA, e.d);
        check("rresp", 32'(RRESP), 32'(e.r));
      end
    end
  end

  task automatic do_write(input logic [4:0] addr, input logic burst, input logic [7:0] len,
                          input int nbeats, input logic wlast_end, input logic wen,
                          input logic [1:0] exp, input int stall);
    @(posedge ACLK); #1;
    AWVALID = 1'b1; AWADDR = addr; AWBURST = burst; AWLEN = len; W_EN = wen;
    wait_for(0, 1'b1, "awready");
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      WVALID = 1'b1;
      WDATA  = wbuf[i];
      WLAST  = wlast_end && (i == nbeats - 1);
      wait_for(1, 1'b1, "wready");
      @(posedge ACLK); #1;
    end
    WVALID = 1'b0;
    WLAST  = 1'b0;
    bq.push_back(exp);
    wait_for(3, 1'b1, "bvalid");
    for (int c = 0; c < stall; c++) begin
      check("bvalid_hold", 32'(BVALID), 32'd1);
      check("bresp_hold", 32'(BRESP), 32'(exp));
      @(posedge ACLK); #1;
    end
    BREADY = 1'b1;
    wait_for(3, 1'b0, "bvalid_clear");
    BREADY = 1'b0;
    W_EN = 1'b1;
  endtask

  task automatic do_read(input logic [4:0] addr, input logic ren, input logic [31:0] ed,
                         input logic [1:0] er, input int stall);
    @(posedge ACLK); #1;
    ARVALID = 1'b1; ARADDR = addr; R_EN = ren;
    wait_for(2, 1'b1, "arready");
    rq.push_back('{d: ed, r: er});
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    check("rvalid_latency", 32'(RVALID), 32'd1);
    for (int c = 0; c < stall; c++) begin
      check("rdata_hold", RDATA, ed);
      check("rvalid_hold", 32'(RVALID), 32'd1);
      @(posedge ACLK); #1;
    end
    RREADY = 1'b1;
    wait_for(4, 1'b0, "rvalid_clear");
    RREADY = 1'b0;
    R_EN = 1'b1;
  endtask

  task automatic check_outputs_zero();
    check("rst_awready", 32'(AWREADY), 32'd0);
    check("rst_wready", 32'(WREADY), 32'd0);
    check("rst_bvalid", 32'(BVALID), 32'd0);
    check("rst_bresp", 32'(BRESP), 32'd0);
    check("rst_arready", 32'(ARREADY), 32'd0);
    check("rst_rvalid", 32'(RVALID), 32'd0);
    check("rst_rdata", RDATA, 32'd0);
    check("rst_rresp", 32'(RRESP), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge ACLK);
    #1;
    check_outputs_zero();
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    check("idle_awready", 32'(AWREADY), 32'd1);
    check("idle_arready", 32'(ARREADY), 32'd1);

    // Incrementing burst of squares at 5..14
    for (int i = 0; i < 10; i++) wbuf[i] = 32'(i * i);
    do_write(5'd5, 1'b1, 8'd10, 10, 1'b1, 1'b1, 2'b00, 0);
    do_read(5'd5, 1'b1, 32'd0, 2'b00, 0);
    do_read(5'd7, 1'b1, 32'd4, 2'b00, 0);
    do_read(5'd11, 1'b1, 32'd36, 2'b00, 0);
    do_read(5'd8, 1'b1, 32'd9, 2'b00, 0);
    do_read(5'd9, 1'b1, 32'd16, 2'b00, 0);
    do_read(5'd14, 1'b1, 32'd81, 2'b00, 0);

    // Fixed burst: every beat lands on word 3
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA + 32'(i);
    do_write(5'd3, 1'b0, 8'd4, 4, 1'b1, 1'b1, 2'b00, 0);
    do_read(5'd3, 1'b1, 32'hD, 2'b00, 0);
    do_read(5'd4, 1'b1, 32'd0, 2'b00, 0);

    // Wrapping incrementing burst, ends on AWLEN count without WLAST
    for (int i = 0; i < 4; i++) wbuf[i] = 32'h100 + 32'(i);
    do_write(5'd30, 1'b1, 8'd4, 4, 1'b0, 1'b1, 2'b00, 0);
    do_read(5'd30, 1'b1, 32'h100, 2'b00, 0);
    do_read(5'd31, 1'b1, 32'h101, 2'b00, 0);
    do_read(5'd0, 1'b1, 32'h102, 2'b00, 0);
    do_read(5'd1, 1'b1, 32'h103, 2'b00, 0);

    // Enables
    wbuf[0] = 32'hDEAD; wbuf[1] = 32'hBEEF;
    do_write(5'd20, 1'b1, 8'd2, 2, 1'b1, 1'b0, 2'b10, 0);
    do_read(5'd20, 1'b1, 32'd0, 2'b00, 0);
    do_read(5'd5, 1'b0, 32'd0, 2'b10, 0);

    // Backpressure on both response channels
    wbuf[0] = 32'h55;
    do_write(5'd16, 1'b1, 8'd1, 1, 1'b1, 1'b1, 2'b00, 5);
    do_read(5'd16, 1'b1, 32'h55, 2'b00, 4);

    // AWLEN of zero means one beat
    wbuf[0] = 32'h77;
    do_write(5'd17, 1'b1, 8'd0, 1, 1'b0, 1'b1, 2'b00, 0);
    do_read(5'd17, 1'b1, 32'h77, 2'b00, 0);
    do_read(5'd18, 1'b1, 32'd0, 2'b00, 0);

    // Reset in the middle of a burst
    @(posedge ACLK); #1;
    AWVALID = 1'b1; AWADDR = 5'd2; AWBURST = 1'b1; AWLEN = 8'd8; W_EN = 1'b1;
    wait_for(0, 1'b1, "awready_mid");
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      WVALID = 1'b1;
      WDATA  = 32'hBAD0 + 32'(i);
      @(posedge ACLK); #1;
    end
    ARESETn = 1'b0;
    WVALID  = 1'b0;
    #1;
    check_outputs_zero();
    repeat (2) @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    check("post_rst_awready", 32'(AWREADY), 32'd1);
    check("post_rst_bvalid", 32'(BVALID), 32'd0);
    do_read(5'd5, 1'b1, 32'd0, 2'b00, 0);
    do_read(5'd30, 1'b1, 32'd0, 2'b00, 0);
    do_read(5'd16, 1'b1, 32'd0, 2'b00, 0);
    do_read(5'd3, 1'b1, 32'd0, 2'b00, 0);
    do_read(5'd2, 1'b1, 32'd0, 2'b00, 0);

    repeat (2) @(posedge ACLK);
    check("bq_drained", 32'(bq.size()), 32'd0);
    check("rq_drained", 32'(rq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_memory.md
Name: axi_memory

Overview:
- Word-addressed on-chip memory slave with a simplified AXI-style interface.
- Write side: address channel, data channel with incrementing or fixed bursts, and a write-response channel.
- Read side: single-beat reads only.
- Used as a scratch/data memory behind an accelerator or CPU master; external enables W_EN and R_EN gate storage and read access.

Parameters:
- word_size, 32, width of one memory word; must equal DATA_WIDTH.
- memory_size, 32, number of words; 2 ≤ memory_size ≤ 2**ADDR_WIDTH.
- ADDR_WIDTH, 5, word-address width.
- DATA_WIDTH, 32, data bus width.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESETn  in  1  asynchronous, active-low reset.
- AWVALID  in  1  write-address valid.
- AWREADY  out  1  write-address ready.
- AWADDR  in  ADDR_WIDTH  burst start word address.
- AWBURST  in  1  1 = incrementing, 0 = fixed.
- AWLEN  in  8  number of beats (not minus-one); 0 is treated as 1.
- WVALID  in  1  write-data valid.
- WREADY  out  1  write-data ready.
- WDATA  in  DATA_WIDTH  write data.
- WLAST  in  1  last beat of the burst.
- BVALID  out  1  write-response valid.
- BREADY  in  1  write-response ready.
- BRESP  out  2  00 = OKAY, 10 = SLVERR.
- ARVALID  in  1  read-address valid.
- ARREADY  out  1  read-address ready.
- ARADDR  in  ADDR_WIDTH  read word address.
- RVALID  out  1  read-data valid.
- RREADY  in  1  read-data ready.
- RDATA  out  DATA_WIDTH  read data.
- RRESP  out  2  00 = OKAY, 10 = SLVERR.
- W_EN  in  1  write enable; when 0, beats are accepted but not stored.
- R_EN  in  1  read enable; when 0, reads return 0 with SLVERR.

Behaviour:
- Reset, asynchronous:
  - All outputs go to 0; both FSMs go to IDLE.
  - All memory words are cleared to 0.
  - Reset during a transaction abandons it; no response is issued.
- Write FSM, states W_IDLE → W_DATA → W_RESP:
  - W_IDLE: AWREADY=1. On AWVALID&AWREADY at a clock edge, latch AWADDR, AWBURST and AWLEN, clear the error flag, and go to W_DATA.
  - W_DATA: WREADY=1, AWREADY=0. On each WVALID&WREADY edge, if W_EN=1 write mem[addr] ← WDATA; if W_EN=0 set the error flag.
  - W_DATA address update: incrementing burst does addr+1 per beat, wrapping modulo memory_size; fixed burst holds addr.
  - W_DATA exit: a beat with WLAST=1, or the AWLEN-th beat, moves to W_RESP. Reaching the AWLEN count without WLAST is legal.
  - W_RESP: BVALID=1, BRESP=SLVERR if the error flag is set, else OKAY. Hold until BREADY=1 at an edge, then go to W_IDLE.
  - WVALID outside W_DATA is ignored.
- Read FSM, states R_IDLE → R_DATA; independent of the write FSM:
  - R_IDLE: ARREADY=1. On ARVALID&ARREADY, load the data register next edge and enter R_DATA.
  - Loaded data: RDATA=mem[ARADDR], RRESP=OKAY if R_EN=1; otherwise RDATA=0, RRESP=SLVERR.
  - R_DATA: RVALID=1, RDATA/RRESP held stable, ARREADY=0. On RREADY edge return to R_IDLE and clear RVALID.
  - Latency: ARVALID handshake at edge N gives RVALID high after edge N; completes on the first edge with RREADY.
- Read/write collision: a read of a word written on the same edge returns the old value (read-before-write).
- Address ≥ memory_size (only possible when memory_size < 2**ADDR_WIDTH): wraps modulo memory_size unless the optional feature is enabled.

Optional Feature:
- AXI_MEM_BOUNDS_CHECK_EN defined:
  - Write beats to addresses ≥ memory_size are dropped and set the error flag → BRESP=SLVERR.
  - Reads of such addresses return RDATA=0, RRESP=SLVERR.
  - Incrementing bursts do not wrap; they run past the end and error.
- Not defined: addresses wrap modulo memory_size; responses are error only from W_EN/R_EN.

Decomposition:
- Package axi_mem_pkg:
  - resp_t with RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - burst_t with BURST_FIXED=0 and BURST_INCR=1.
  - Enums w_state_t and r_state_t.
- One sub-module axi_mem_array: storage with reset clear, one write port and one synchronous read port.
- axi_memory top holds both FSMs.

Test Plan:
- Incrementing write: AWADDR=5, AWLEN=10, WDATA=i*i for i=0..9, WLAST on beat 9, W_EN=1 → BVALID then BRESP=00; mem[5..14]=0,1,4,…,81.
- Single reads with R_EN=1, after the write above → RDATA/RRESP=00 each:
  - ARADDR=5 → 0
  - ARADDR=7 → 4
  - ARADDR=11 → 36
  - ARADDR=8 → 9
  - ARADDR=9 → 16
- Fixed burst plus wrap:
  - AWBURST=0, AWADDR=3, 4 beats 0xA..0xD → mem[3]=0xD.
  - Incrementing burst at 30, 4 beats → words 30, 31, 0, 1 written.
- Enables:
  - W_EN=0 burst at 20 → BRESP=10, mem[20] unchanged.
  - R_EN=0 read → RDATA=0, RRESP=10.
- Backpressure/reset:
  - BREADY held low 5 cycles → BVALID and BRESP stable throughout.
  - RREADY held low → RDATA stable.
  - ARESETn pulsed mid-burst → all outputs 0, FSMs idle, mem all 0.
